// File: rtl/idli_mem_arb_if.sv
// Bus bundle between the idli core, the memory arbiter and the quad-SPI pins.
//   Fetch port : f_req, f_addr -> f_ack
//   Data port  : d_req, d_we, d_addr, d_wdata -> d_ack
//   Shared     : rdata (valid with either ack), busy
//   SRAM pins  : mem_cs_n, mem_sck, mem_dq_out, mem_dq_oe, mem_dq_in
// slave  : arbiter side
// master : requesters plus pin side (core, pin mapping, or a bench model)
interface idli_mem_arb_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_cs_n;
    logic        mem_sck;
    logic [3:0]  mem_dq_out;
    logic [3:0]  mem_dq_oe;
    logic [3:0]  mem_dq_in;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dq_in,
        output f_ack, d_ack, rdata, busy, mem_cs_n, mem_sck, mem_dq_out, mem_dq_oe
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dq_in,
        input  f_ack, d_ack, rdata, busy, mem_cs_n, mem_sck, mem_dq_out, mem_dq_oe
    );
endinterface

// File: rtl/idli_mem_arb.sv
// Arbitrates the idli fetch port and data port onto one quad-SPI SRAM channel.
// Each grant runs a full transaction: CS low, command byte, 16-bit word
// address, optional dummy nibbles (reads only), 16-bit data, deselect.
// Every nibble lasts two clk cycles (phase 0: sck low, dq updated; phase 1:
// sck high, read data sampled at the closing edge).
//   clk, rst : clock, synchronous active-high reset
//   bus      : idli_mem_arb_if.slave (request ports, acks, rdata, busy, SRAM pins)
module idli_mem_arb #(
    parameter int         DUMMY_NIBBLES = 2,
    parameter logic [7:0] CMD_READ      = 8'h03,
    parameter logic [7:0] CMD_WRITE     = 8'h02
) (
    input  logic          clk,
    input  logic          rst,
    idli_mem_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);

    state_t      state;
    logic        phase;
    logic [3:0]  cnt;
    logic        gnt_fetch;
    logic        last_data;  // 1 = data port won the previous grant
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;

    // Fetch wins unless data also requests and fetch had the last turn.
    logic        grant_f;
    logic        g_we;
    logic [15:0] g_addr;
    logic [7:0]  g_cmd;
    logic [7:0]  cmd;

    assign grant_f = bus.f_req & (~bus.d_req | last_data);
    assign g_we    = grant_f ? 1'b0 : bus.d_we;
    assign g_addr  = grant_f ? bus.f_addr : bus.d_addr;
    assign g_cmd   = g_we ? CMD_WRITE : CMD_READ;
    assign cmd     = we ? CMD_WRITE : CMD_READ;

    function automatic logic [3:0] nib16(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[15:12];
            2'd1:    return v[11:8];
            2'd2:    return v[7:4];
            default: return v[3:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            phase          <= 1'b0;
            cnt            <= '0;
            gnt_fetch      <= 1'b0;
            last_data      <= 1'b1;
            we             <= 1'b0;
            addr           <= '0;
            wdata          <= '0;
            bus.f_ack      <= 1'b0;
            bus.d_ack      <= 1'b0;
            bus.rdata      <= '0;
            bus.busy       <= 1'b0;
            bus.mem_cs_n   <= 1'b1;
            bus.mem_sck    <= 1'b0;
            bus.mem_dq_out <= '0;
            bus.mem_dq_oe  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.f_req | bus.d_req) begin
                        gnt_fetch      <= grant_f;
                        last_data      <= ~grant_f;
                        we             <= g_we;
                        addr           <= g_addr;
                        wdata          <= bus.d_wdata;
                        state          <= CMD;
                        phase          <= 1'b0;
                        cnt            <= '0;
                        bus.busy       <= 1'b1;
                        bus.mem_cs_n   <= 1'b0;
                        bus.mem_dq_oe  <= 4'hF;
                        bus.mem_dq_out <= g_cmd[7:4];
                    end
                end
                DONE: begin
                    bus.f_ack <= 1'b0;
                    bus.d_ack <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    if (!phase) begin
                        phase       <= 1'b1;
                        bus.mem_sck <= 1'b1;
                    end else begin
                        // End of a nibble: sample, advance, and set up the next nibble.
                        phase       <= 1'b0;
                        bus.mem_sck <= 1'b0;
                        cnt         <= cnt + 4'd1;
                        if (state == DATA && !we)
                            bus.rdata <= {bus.rdata[11:0], bus.mem_dq_in};
                        case (state)
                            CMD: begin
                                if (cnt[0]) begin
                                    state          <= ADDR;
                                    cnt            <= '0;
                                    bus.mem_dq_out <= addr[15:12];
                                end else begin
                                    bus.mem_dq_out <= cmd[3:0];
                                end
                            end
                            ADDR: begin
                                if (cnt[1:0] == 2'd3) begin
                                    cnt <= '0;
                                    if (!we && DUMMY_NIBBLES != 0) begin
                                        state          <= DUMMY;
                                        bus.mem_dq_oe  <= '0;
                                        bus.mem_dq_out <= '0;
                                    end else begin
                                        state          <= DATA;
                                        bus.mem_dq_oe  <= we ? 4'hF : 4'h0;
                                        bus.mem_dq_out <= we ? wdata[15:12] : 4'h0;
                                    end
                                end else begin
                                    bus.mem_dq_out <= nib16(addr, cnt[1:0] + 2'd1);
                                end
                            end
                            DUMMY: begin
                                if (cnt == DUMMY_LAST) begin
                                    state <= DATA;
                                    cnt   <= '0;
                                end
                            end
                            DATA: begin
                                if (cnt[1:0] == 2'd3) begin
                                    state          <= DONE;
                                    bus.mem_cs_n   <= 1'b1;
                                    bus.mem_dq_oe  <= '0;
                                    bus.mem_dq_out <= '0;
                                    if (gnt_fetch) bus.f_ack <= 1'b1;
                                    else           bus.d_ack <= 1'b1;
                                end else begin
                                    bus.mem_dq_out <= we ? nib16(wdata, cnt[1:0] + 2'd1) : 4'h0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_idli_mem_arb.sv
module tb_idli_mem_arb;
    localparam int DN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idli_mem_arb_if bus ();
    idli_mem_arb_if b0 ();

    idli_mem_arb #(.DUMMY_NIBBLES(DN)) dut (.clk(clk), .rst(rst), .bus(bus));
    idli_mem_arb #(.DUMMY_NIBBLES(0))  u_d0 (.clk(clk), .rst(rst), .bus(b0));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM model: word memory with a fixed pattern for unwritten words.
    logic [15:0] sram [logic [15:0]];

    function automatic logic [15:0] rd(input logic [15:0] a);
        return sram.exists(a) ? sram[a] : (a ^ 16'hA5A5);
    endfunction

    int          k = 0;
    logic [7:0]  m_cmd;
    logic [15:0] m_addr, m_wd, m_t;
    logic [63:0] rec_out, rec_oe;

    always @(negedge bus.mem_cs_n) begin
        k = 0; rec_out = '0; rec_oe = '0;
    end

    always @(posedge bus.mem_sck) begin
        rec_out = {rec_out[59:0], bus.mem_dq_out};
        rec_oe  = {rec_oe[59:0], bus.mem_dq_oe};
        if (k < 2) m_cmd = {m_cmd[3:0], bus.mem_dq_out};
        else if (k < 6) m_addr = {m_addr[11:0], bus.mem_dq_out};
        else if (m_cmd == 8'h02) begin
            m_wd = {m_wd[11:0], bus.mem_dq_out};
            if (k == 9) sram[m_addr] = m_wd;
        end else if (k >= 6 + DN) begin
            m_t = rd(m_addr) << (4 * (k - 6 - DN));
            bus.mem_dq_in = m_t[15:12];
        end
        k++;
    end

    // Zero-dummy build: each nibble returns its own index on the bus.
    int k0 = 0;
    always @(negedge b0.mem_cs_n) k0 = 0;
    always @(posedge b0.mem_sck) begin
        b0.mem_dq_in = 4'(k0);
        k0++;
    end

    typedef struct {
        bit          fetch;
        bit          rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit f, input bit r, input logic [15:0] d, input int lat);
        exp_t e;
        e.fetch = f; e.rd = r; e.data = d; e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.f_ack || bus.d_ack) begin
            chk("ack_exclusive", {63'd0, bus.f_ack & bus.d_ack}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {62'd0, bus.f_ack, bus.d_ack}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", {63'd0, bus.f_ack}, {63'd0, e.fetch});
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (e.rd) chk("rdata", {48'd0, bus.rdata}, {48'd0, e.data});
            end
        end
    end

    task automatic wait_ack(input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.f_ack || bus.d_ack) && n < maxc);
        chk("ack_seen", {63'd0, bus.f_ack | bus.d_ack}, 64'd1);
    endtask

    initial begin
        bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_dq_in = 0;
        b0.f_req = 0; b0.f_addr = 0; b0.d_req = 0; b0.d_we = 0;
        b0.d_addr = 0; b0.d_wdata = 0; b0.mem_dq_in = 0;
        sram[16'h1234] = 16'hABCD;

        repeat (3) @(negedge clk);
        chk("reset_vals", {37'd0, bus.mem_cs_n, bus.mem_sck, bus.mem_dq_out, bus.mem_dq_oe,
                           bus.f_ack, bus.d_ack, bus.rdata, bus.busy},
            {37'd0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0});
        rst = 0;
        @(negedge clk);

        // Single fetch
        bus.f_req = 1; bus.f_addr = 16'h1234;
        push(1, 1, rd(16'h1234), 25);
        @(negedge clk);
        chk("busy_cs_active", {62'd0, bus.busy, bus.mem_cs_n}, 64'd2);
        wait_ack(40);
        bus.f_req = 0;
        chk("fetch_cs_done", {63'd0, bus.mem_cs_n}, 64'd1);
        chk("fetch_dq_seq", rec_out[47:0], 64'h031234000000);
        chk("fetch_oe_seq", rec_oe[47:0], 64'hFFFFFF000000);
        chk("fetch_nibbles", 64'(k), 64'd12);
        @(negedge clk);
        chk("idle_after_done", {61'd0, bus.mem_cs_n, bus.f_ack, bus.busy}, 64'd4);

        // Data write
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h00F0; bus.d_wdata = 16'hBEEF;
        push(0, 0, 16'h0, 21);
        wait_ack(40);
        bus.d_req = 0; bus.d_we = 0;
        chk("write_dq_seq", rec_out[39:0], 64'h0200F0BEEF);
        chk("write_oe_seq", rec_oe[39:0], 64'hFFFFFFFFFF);
        chk("write_nibbles", 64'(k), 64'd10);
        chk("write_stored", {48'd0, rd(16'h00F0)}, 64'hBEEF);
        @(negedge clk);

        // Tie: fetch, data, fetch
        bus.f_req = 1; bus.f_addr = 16'h0100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0200;
        push(1, 1, rd(16'h0100), 25);
        push(0, 1, rd(16'h0200), 51);
        push(1, 1, rd(16'h0100), 77);
        wait_ack(40);
        wait_ack(40);
        wait_ack(40);
        bus.f_req = 0; bus.d_req = 0;
        @(negedge clk);

        // Capture at grant
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0AA0; bus.d_wdata = 16'h1357;
        push(0, 0, 16'h0, 21);
        @(negedge clk);
        bus.d_addr = 16'hFFFF; bus.d_req = 0; bus.d_wdata = 16'h0; bus.d_we = 0;
        wait_ack(40);
        chk("capture_addr", {48'd0, rd(16'h0AA0)}, 64'h1357);
        chk("capture_no_ffff", {63'd0, sram.exists(16'hFFFF) != 0}, 64'd0);
        @(negedge clk);
        chk("ack_one_cycle", {63'd0, bus.d_ack}, 64'd0);
        repeat (30) @(negedge clk);

        // Reset during ADDR
        bus.f_req = 1; bus.f_addr = 16'h1234;
        repeat (6) @(negedge clk);
        chk("in_addr_phase", {59'd0, bus.mem_cs_n, bus.mem_dq_oe}, 64'h0F);
        rst = 1; bus.f_req = 0;
        @(negedge clk);
        chk("reset_mid", {56'd0, bus.mem_cs_n, bus.mem_dq_oe, bus.busy, bus.f_ack, bus.d_ack},
            {56'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0});
        rst = 0;
        repeat (2) @(negedge clk);
        bus.f_req = 1; bus.f_addr = 16'h1234;
        push(1, 1, rd(16'h1234), 25);
        wait_ack(40);
        bus.f_req = 0;
        @(negedge clk);

        // Zero-dummy build
        begin
            int c0, n;
            c0 = cyc; n = 0;
            b0.f_req = 1; b0.f_addr = 16'h0055;
            do begin
                @(negedge clk);
                n++;
            end while (!b0.f_ack && n < 40);
            b0.f_req = 0;
            chk("d0_ack", {63'd0, b0.f_ack}, 64'd1);
            chk("d0_latency", 64'(cyc - c0), 64'd21);
            chk("d0_rdata", {48'd0, b0.rdata}, 64'h6789);
            chk("d0_nibbles", 64'(k0), 64'd10);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
